mvu_jump_agu: RTL and testbench

//  Parametrised N-level nested-loop address generator for MVU data/weight banks.

---
 rtl/mvu_pkg.sv | 25 ++
 rtl/mvu_jump_agu_lvl.sv | 42 ++++
 rtl/mvu_jump_agu.sv | 113 +++++++++++
 tb/tb_mvu_jump_agu.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// mvu_pkg: shared MVU widths, AGU defaults, AGU config bundle and FSM encodings.
//   BDBANKA        data bank address width
//   BCNTDWN        total-beat countdown width
//   AGU_NJUMPS_DEF default number of nested AGU loop levels
//   BAGULEN        per-level loop length field width
//   agu_cfg_t      base / per-level jump / per-level length / countdown bundle
package mvu_pkg;

  localparam int BDBANKA        = 15;
  localparam int BCNTDWN        = 29;
  localparam int AGU_NJUMPS_DEF = 5;
  localparam int BAGULEN        = 15;

  typedef struct packed {
    logic [BDBANKA-1:0]                       base;
    logic [AGU_NJUMPS_DEF-1:0][BDBANKA-1:0]   jump;
    logic [AGU_NJUMPS_DEF-1:0][BAGULEN-1:0]   length;
    logic [BCNTDWN-1:0]                       cntdwn;
  } agu_cfg_t;

  localparam logic [1:0] AGU_IDLE = 2'd0;
  localparam logic [1:0] AGU_RUN  = 2'd1;
  localparam logic [1:0] AGU_DONE = 2'd2;

endpackage

// File: rtl/mvu_jump_agu_lvl.sv
// mvu_jump_agu_lvl: one loop level of the jump AGU.
//   clk, rst   clock, synchronous active-high reset
//   load_i     latch len_i as reload value and preset the counter
//   len_i      per-level length (level runs len_i+1 iterations)
//   step_i     decrement the counter (this level advances)
//   reload_i   restore the counter to the latched length (a higher level advanced)
//   is_zero_o  counter has reached zero (this level is on its last iteration)
module mvu_jump_agu_lvl
  import mvu_pkg::*;
#(
  parameter int BLEN = BAGULEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [BLEN-1:0] len_i,
  input  logic            step_i,
  input  logic            reload_i,
  output logic            is_zero_o
);

  localparam logic [BLEN-1:0] ONE = BLEN'(1);

  logic [BLEN-1:0] cnt_q, len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (load_i) begin
      len_q <= len_i;
      cnt_q <= len_i;
    end else if (step_i) begin
      cnt_q <= cnt_q - ONE;
    end else if (reload_i) begin
      cnt_q <= len_q;
    end
  end

  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/mvu_jump_agu.sv
// mvu_jump_agu: N-level nested-loop address generator for MVU bank reads.
//   clk, rst    clock, synchronous active-high reset
//   start       one-cycle pulse, accepted only in IDLE, latches the config
//   base        first address
//   jump        signed per-level step, slice i = level i (level 0 innermost)
//   length      per-level reload value, level i runs length[i]+1 iterations
//   cntdwn      number of beats to emit (0: straight to DONE, no beats)
//   addr        current address, addr_valid qualifies addr and z
//   addr_ready  beat accepted on addr_valid & addr_ready
//   z           z[i]=1: current beat closes a level-i loop
//   busy        high while beats are being produced
//   done        one-cycle pulse after the final beat is accepted
module mvu_jump_agu
  import mvu_pkg::*;
#(
  parameter int NJUMPS = AGU_NJUMPS_DEF,
  parameter int BADDR  = BDBANKA,
  parameter int BLEN   = BAGULEN,
  parameter int BCNT   = BCNTDWN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BADDR-1:0]              base,
  input  logic [NJUMPS-1:0][BADDR-1:0]  jump,
  input  logic [NJUMPS-1:0][BLEN-1:0]   length,
  input  logic [BCNT-1:0]               cntdwn,
  output logic [BADDR-1:0]              addr,
  output logic                          addr_valid,
  input  logic                          addr_ready,
  output logic [NJUMPS-1:0]             z,
  output logic                          busy,
  output logic                          done
);

  localparam logic [BCNT-1:0] CNT_ONE = BCNT'(1);

  logic [1:0]                     state_q, state_d;
  logic [BADDR-1:0]               addr_q;
  logic [BCNT-1:0]                cnt_q;
  logic [NJUMPS-1:0][BADDR-1:0]   jump_q;

  logic              load, adv;
  logic [NJUMPS-1:0] lvl_zero, lvl_step, lvl_reload;
  // nz_below[i]: some level below i still has iterations left
  logic [NJUMPS:0]   nz_below;
  logic [BADDR-1:0]  jsel;

  assign load = (state_q == AGU_IDLE) && start && (cntdwn != '0);
  assign adv  = (state_q == AGU_RUN) && addr_ready;

  assign nz_below[0] = 1'b0;

  // Priority encoder: the lowest non-zero level steps, every level below it
  // reloads, levels above hold. With all levels at zero, every level reloads.
  for (genvar i = 0; i < NJUMPS; i++) begin : g_lvl
    assign nz_below[i+1] = nz_below[i] | ~lvl_zero[i];
    assign lvl_step[i]   = adv & ~nz_below[i] & ~lvl_zero[i];
    assign lvl_reload[i] = adv & ~nz_below[i] &  lvl_zero[i];
    assign z[i]          = addr_valid & ~nz_below[i+1];

    mvu_jump_agu_lvl #(.BLEN(BLEN)) u_lvl (
      .clk       (clk),
      .rst       (rst),
      .load_i    (load),
      .len_i     (length[i]),
      .step_i    (lvl_step[i]),
      .reload_i  (lvl_reload[i]),
      .is_zero_o (lvl_zero[i])
    );
  end

  // Full wrap (no level steps) takes the outermost jump.
  always_comb begin
    jsel = jump_q[NJUMPS-1];
    for (int i = 0; i < NJUMPS; i++)
      if (lvl_step[i]) jsel = jump_q[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AGU_IDLE: if (start) state_d = (cntdwn != '0) ? AGU_RUN : AGU_DONE;
      AGU_RUN:  if (adv && cnt_q == CNT_ONE) state_d = AGU_DONE;
      default:  state_d = AGU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AGU_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      jump_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        addr_q <= base;
        cnt_q  <= cntdwn;
        jump_q <= jump;
      end else if (adv) begin
        addr_q <= addr_q + jsel;
        cnt_q  <= cnt_q - CNT_ONE;
      end
    end
  end

  assign addr       = addr_q;
  assign addr_valid = (state_q == AGU_RUN);
  assign busy       = (state_q == AGU_RUN);
  assign done       = (state_q == AGU_DONE);

endmodule

// File: tb/tb_mvu_jump_agu.sv
module tb_mvu_jump_agu;
  import mvu_pkg::*;

  localparam int NJ = 2;
  localparam int BA = 15;
  localparam int BL = 15;
  localparam int BC = 29;

  logic                  clk = 1'b0;
  logic                  rst, start, addr_ready, addr_valid, busy, done;
  logic [BA-1:0]         base, addr;
  logic [NJ-1:0][BA-1:0] jump;
  logic [NJ-1:0][BL-1:0] length;
  logic [BC-1:0]         cntdwn;
  logic [NJ-1:0]         z;

  always #5 clk = ~clk;

  mvu_jump_agu #(.NJUMPS(NJ), .BADDR(BA), .BLEN(BL), .BCNT(BC)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .jump(jump),
    .length(length), .cntdwn(cntdwn), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .z(z), .busy(busy), .done(done)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    agu_cfg_t      cfg;
    int            n;
    logic [BA-1:0] ea[6];
    logic [NJ-1:0] ez[6];
    int            done_cyc;
  } vec_t;

  vec_t vt[2];

  logic [BA-1:0] got_a[$], ex_a[$];
  logic [NJ-1:0] got_z[$], ex_z[$];
  int            done_cyc;

  // Apply a config and pulse start; returns at the first negedge where the
  // DUT has seen start.
  task automatic do_start(input agu_cfg_t c);
    base   = c.base;
    jump   = c.jump[NJ-1:0];
    length = c.length[NJ-1:0];
    cntdwn = c.cntdwn;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Observe beats at negedges until done. Ready is random (rnd) or held low
  // for stall_len cycles while beat index stall_at is presented. A spurious
  // start with a different base is driven at restart_cyc.
  task automatic collect(input int stall_at, input int stall_len, input bit rnd,
                         input int restart_cyc, input int max_cyc);
    int            stalled = 0;
    bit            hold = 0, r;
    logic [BA-1:0] ha = '0;
    logic [NJ-1:0] hz = '0;
    got_a.delete(); got_z.delete(); done_cyc = -1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      if (hold) begin
        chk("stall_addr", addr, ha);
        chk("stall_z", z, hz);
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_in_done", busy, 0);
        chk("valid_in_done", addr_valid, 0);
        break;
      end
      chk("busy_in_run", busy, 1);
      start = (cyc == restart_cyc);
      if (start) base = 15'd500;
      if (rnd) r = ($urandom_range(0, 3) != 0);
      else if (addr_valid && got_a.size() == stall_at && stalled < stall_len) begin
        r = 1'b0; stalled++;
      end else r = 1'b1;
      addr_ready = r;
      hold = addr_valid && !r; ha = addr; hz = z;
      if (addr_valid && r) begin got_a.push_back(addr); got_z.push_back(z); end
      @(negedge clk);
    end
    start = 1'b0;
    addr_ready = 1'b1;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    else begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
  endtask

  task automatic cmp_vec(input string nm, input int k, input int dly);
    chk({nm, "_beats"}, got_a.size(), vt[k].n);
    for (int b = 0; b < vt[k].n && b < got_a.size(); b++) begin
      chk({nm, "_addr"}, got_a[b], vt[k].ea[b]);
      chk({nm, "_z"}, got_z[b], vt[k].ez[b]);
    end
    chk({nm, "_done_cyc"}, done_cyc, vt[k].done_cyc + dly);
  endtask

  // Reference: level digits form a mixed-radix odometer over beat index;
  // a beat closes level i when digits 0..i are all at their length, and the
  // address then moves by the jump of the lowest digit not at its length.
  function automatic void model(input logic [BA-1:0] b, input logic [NJ-1:0][BA-1:0] j,
                                input int l0, input int l1, input int n);
    int p, m, d0, d1, lv;
    logic [BA-1:0] a;
    logic [NJ-1:0] zz;
    ex_a.delete(); ex_z.delete();
    p = (l0 + 1) * (l1 + 1);
    a = b;
    for (int t = 0; t < n; t++) begin
      m  = t % p;
      d0 = m % (l0 + 1);
      d1 = (m / (l0 + 1)) % (l1 + 1);
      zz[0] = (d0 == l0);
      zz[1] = zz[0] && (d1 == l1);
      ex_a.push_back(a); ex_z.push_back(zz);
      lv = (d0 != l0) ? 0 : 1;
      a  = a + j[lv];
    end
  endfunction

  initial begin
    agu_cfg_t c;

    vt[0].cfg = '0;
    vt[0].cfg.base = 15'd100;
    vt[0].cfg.jump[0] = 15'd1;  vt[0].cfg.jump[1] = 15'h7FFD;
    vt[0].cfg.length[0] = 15'd2; vt[0].cfg.length[1] = 15'd1;
    vt[0].cfg.cntdwn = 29'd6;
    vt[0].n = 6;
    vt[0].ea = '{15'd100, 15'd101, 15'd102, 15'd99, 15'd100, 15'd101};
    vt[0].ez = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11};
    vt[0].done_cyc = 6;

    vt[1].cfg = '0;
    vt[1].cfg.base = 15'd32767;
    vt[1].cfg.jump[0] = 15'd1;  vt[1].cfg.jump[1] = 15'd5;
    vt[1].cfg.length[0] = 15'd3; vt[1].cfg.length[1] = 15'd0;
    vt[1].cfg.cntdwn = 29'd3;
    vt[1].n = 3;
    vt[1].ea = '{15'd32767, 15'd0, 15'd1, 15'd0, 15'd0, 15'd0};
    vt[1].ez = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vt[1].done_cyc = 3;

    rst = 1'b1; start = 1'b0; addr_ready = 1'b1;
    base = '0; jump = '0; length = '0; cntdwn = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: nominal sequence and address wrap.
    for (int k = 0; k < 2; k++) begin
      do_start(vt[k].cfg);
      collect(-1, 0, 1'b0, -1, 40);
      cmp_vec($sformatf("vec%0d", k), k, 0);
    end

    // Stall for 3 cycles while beat 2 is presented.
    do_start(vt[0].cfg);
    collect(1, 3, 1'b0, -1, 40);
    cmp_vec("stall", 0, 3);

    // Zero beat count: straight to DONE, no beat ever valid.
    c = vt[0].cfg; c.cntdwn = '0;
    do_start(c);
    collect(-1, 0, 1'b0, -1, 10);
    chk("zero_beats", got_a.size(), 0);
    chk("zero_done_cyc", done_cyc, 0);

    // Start during RUN is ignored.
    do_start(vt[0].cfg);
    collect(-1, 0, 1'b0, 2, 40);
    cmp_vec("restart", 0, 0);

    // Reset while beat 3 is presented, then a clean rerun.
    do_start(vt[0].cfg);
    addr_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_addr", addr, 102);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_addr", addr, 0);
    chk("midrst_valid", addr_valid, 0);
    chk("midrst_z", z, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done, 0);
    do_start(vt[0].cfg);
    collect(-1, 0, 1'b0, -1, 40);
    cmp_vec("rerun", 0, 0);

    // Randomized configs and backpressure against the odometer model.
    for (int t = 0; t < 25; t++) begin
      int l0, l1, n;
      c = '0;
      c.base    = BA'($urandom);
      c.jump[0] = BA'($urandom);
      c.jump[1] = BA'($urandom);
      l0 = $urandom_range(0, 3);
      l1 = $urandom_range(0, 3);
      n  = $urandom_range(1, 24);
      c.length[0] = BL'(l0);
      c.length[1] = BL'(l1);
      c.cntdwn    = BC'(n);
      model(c.base, c.jump[NJ-1:0], l0, l1, n);
      do_start(c);
      collect(-1, 0, 1'b1, $urandom_range(0, 6), 50 * n + 20);
      chk("rnd_beats", got_a.size(), n);
      for (int b = 0; b < n && b < got_a.size(); b++) begin
        chk("rnd_addr", got_a[b], ex_a[b]);
        chk("rnd_z", got_z[b], ex_z[b]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
